rgb_to_gray: RTL and testbench
==============================

# rgb_to_gray

Byte-stream colour-to-luma converter that sits directly downstream of the image buffer stage. It receives the buffer's read-back stream as three-byte pixels (B, G, R order) over a four-phase request/acknowledge handshake. It computes an 8-bit luma value and a thresholded binary bit per pixel, and forwards them through the same handshake style to the binarisation/QR-locate stage. It also counts pixels per frame and flags truncated pixels at frame end.

## Interface
- THRESH, default 8'd128: binarisation threshold; `om_bin` = 1 when luma ≥ THRESH.
- CNT_W, default 17: pixel counter width; covers an 18-bit byte address space divided by 3.
- clk, input, 1: single clock; all logic runs on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- im_start, input, 1: upstream frame envelope; high for the whole frame.
- im_work, input, 1: upstream byte request; `im_data` is stable while it is high.
- im_data, input, 8: upstream byte.
- om_ack, output, 1: acknowledge to upstream; returns to the upstream stage's `im_work`.
- om_start, output, 1: downstream frame envelope.
- om_work, output, 1: downstream pixel request.
- om_data, output, 8: luma byte; valid while `om_work` is high.
- om_bin, output, 1: thresholded pixel; valid with `om_data`.
- im_ack, input, 1: downstream acknowledge.
- om_pix_cnt, output, CNT_W: pixels emitted in the current or last frame.
- om_frag, output, 1: sticky flag, set when a frame ended with 1–2 leftover bytes.

## Operation
- Input FSM states: I_IDLE, I_ACK, I_REL.
  - I_IDLE → I_ACK when `im_work` is sampled high and the byte is accepted. The byte is latched and `byte_cnt` advances 0→1→2→0.
  - I_ACK: `om_ack` = 1; move to I_REL.
  - I_REL: hold `om_ack` = 1 until `im_work` is sampled low; then drop `om_ack` and return to I_IDLE.
- Byte acceptance rules:
  - Byte 0 = B and byte 1 = G are always accepted.
  - Byte 2 = R is accepted only when the output slot is empty. Otherwise the block stalls in I_IDLE with `om_ack` = 0 until the slot frees.
- Luma:
  - Y = (77·R + 150·G + 29·B + 128) >> 8.
  - 16-bit unsigned accumulate. Maximum intermediate value is 65408, so there is no overflow; the result saturates naturally at 255.
  - One pipeline register holds the three products, a second holds Y.
- Output FSM states: O_IDLE, O_REQ, O_REL.
  - O_IDLE → O_REQ when a new Y is ready: `om_work` = 1, data held.
  - O_REQ → O_REL when `im_ack` is sampled high: `om_work` = 0 and `om_pix_cnt` increments.
  - O_REL → O_IDLE when `im_ack` is sampled low. This frees the slot.
- Frame control:
  - Rising edge of `im_start` while `om_start` = 0: set `om_start`, clear `om_pix_cnt`, `byte_cnt` and `om_frag`.
  - Falling edge of `im_start`: enter drain. `om_start` drops the cycle after the output FSM reaches O_IDLE with no pixel in the pipeline.
  - If `byte_cnt` ≠ 0 at the falling edge: discard the partial pixel and set `om_frag`.
  - Bytes requested while `im_start` = 0 are acknowledged and discarded.
- `om_pix_cnt` saturates at all-ones; it does not wrap.

## Timing
- Reset values: `om_ack`, `om_start`, `om_work`, `om_bin`, `om_frag` = 0; `om_data` = 0; `om_pix_cnt` = 0. Both FSMs are idle and `byte_cnt` = 0.
- Reset mid-frame returns every register to its reset value immediately. Nothing resumes after reset.
- `om_ack` rises 1 cycle after `im_work` is sampled high, and falls 1 cycle after `im_work` is sampled low.
- Latency: R byte sampled at cycle t → `om_work` high at t+3 (latch, product, sum stages).
- `om_data` and `om_bin` are stable from the `om_work` rise until `im_ack` is sampled high.
- Simultaneous events:
  - Slot freeing and a waiting R byte in the same cycle: the R byte is accepted in that cycle.
  - `im_start` falling in the same cycle a byte is sampled: the byte is accepted first, then the frame-end check runs.
- Maximum throughput is one pixel per 12 cycles, bounded by the handshake round trips.

## Structure
- Shared package `img_pkg`:
  - Luma coefficients KR = 77, KG = 150, KB = 29.
  - Rounding constant 128.
  - Input and output FSM state encodings.
  - Default THRESH.
- One sub-module, `luma_calc`: two-stage pipelined multiply-accumulate.
  - Inputs: r, g, b, in_valid.
  - Outputs: y, out_valid.
- Handshake FSMs, frame control and counters live in the top level.

## Test plan
- Frame of 1 pixel, B = 0, G = 0, R = 255 → `om_data` = 77, `om_bin` = 0, `om_pix_cnt` = 1, `om_start` falls after `im_ack` low, `om_frag` = 0.
- Pixel (255, 255, 255) then pixel (0, 0, 0) → `om_data` = 255 then 0; `om_bin` = 1 then 0; each pixel has exactly one `om_work` pulse.
- Downstream holds `im_ack` low for 50 cycles after `om_work` → the second pixel's R byte stays unacknowledged (`om_ack` = 0) and its B and G bytes are accepted; no pixel is lost.
- Frame of 7 bytes → 2 pixels out, `om_frag` = 1, `om_pix_cnt` = 2.
- `rst_n` asserted while `om_work` = 1 → all outputs read 0 in the same cycle; the next frame starts cleanly with `om_pix_cnt` = 0.
- B = 10, G = 200, R = 120 → Y = (290 + 30000 + 9240 + 128) >> 8 = 154; `om_bin` = 1 with THRESH = 128.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants, state encodings and pixel type for the image pipeline stages.
package img_pkg;

    localparam logic [7:0]  KR         = 8'd77;
    localparam logic [7:0]  KG         = 8'd150;
    localparam logic [7:0]  KB         = 8'd29;
    localparam logic [15:0] LUMA_RND   = 16'd128;
    localparam logic [7:0]  THRESH_DEF = 8'd128;

    typedef enum logic [1:0] {I_IDLE, I_ACK, I_REL} in_state_e;
    typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} out_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] k);
        return 16'(a) * 16'(k);
    endfunction

endpackage

// File: rtl/luma_calc.sv
// Two-stage luma pipeline: registered coefficient products, then rounded sum >> 8.
module luma_calc
    import img_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic       in_valid,
    output logic [7:0] y,
    output logic       out_valid
);

    localparam int STAGES = 2;

    logic [15:0]       pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
    logic [15:0]       sum;
    logic [7:0]        y_q, y_d;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:1]   vld_q;

    assign vld_pipe = {vld_q, in_valid};

    // Worst case 65408 fits in 16 bits, so the top byte saturates at 255 by itself.
    always_comb begin
        pr_d = mul8(r, KR);
        pg_d = mul8(g, KG);
        pb_d = mul8(b, KB);
        sum  = pr_q + pg_q + pb_q + LUMA_RND;
        y_d  = 8'(sum >> 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q  <= '0;
            pg_q  <= '0;
            pb_q  <= '0;
            y_q   <= '0;
            vld_q <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) begin
                pr_q <= pr_d;
                pg_q <= pg_d;
                pb_q <= pb_d;
            end
            if (vld_pipe[1]) y_q <= y_d;
        end
    end

    assign y         = y_q;
    assign out_valid = vld_q[STAGES];

endmodule

// File: rtl/rgb_to_gray.sv
// B,G,R byte stream to luma + threshold bit, four-phase handshakes on both sides,
// with per-frame pixel count and a sticky flag for truncated trailing pixels.
module rgb_to_gray
    import img_pkg::*;
#(
    parameter logic [7:0] THRESH = THRESH_DEF,
    parameter int         CNT_W  = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             im_start,
    input  logic             im_work,
    input  logic [7:0]       im_data,
    output logic             om_ack,
    output logic             om_start,
    output logic             om_work,
    output logic [7:0]       om_data,
    output logic             om_bin,
    input  logic             im_ack,
    output logic [CNT_W-1:0] om_pix_cnt,
    output logic             om_frag
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    in_state_e        in_state_q, in_state_d;
    out_state_e       out_state_q, out_state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    pix_t             pix_q, pix_d;
    logic             pix_vld_q, pix_vld_d;
    logic             slot_busy_q, slot_busy_d;
    logic             start_q, start_d;
    logic             drain_q, drain_d;
    logic             im_start_q, im_start_d;
    logic             om_ack_q, om_ack_d;
    logic             om_work_q, om_work_d;
    logic [7:0]       om_data_q, om_data_d;
    logic             om_bin_q, om_bin_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             frag_q, frag_d;

    logic       in_frame, start_rise, start_fall, slot_free, take, use_byte;
    logic [7:0] y;
    logic       y_vld;

    luma_calc u_luma (
        .clk       (clk),
        .rst_n     (rst_n),
        .r         (pix_q.r),
        .g         (pix_q.g),
        .b         (pix_q.b),
        .in_valid  (pix_vld_q),
        .y         (y),
        .out_valid (y_vld)
    );

    // The slot covers a pixel from R acceptance until downstream releases it,
    // so it guards the pipeline as well as the output register.
    always_comb begin
        in_frame   = start_q && !drain_q;
        start_rise = im_start && !im_start_q && !start_q;
        start_fall = !im_start && im_start_q;
        slot_free  = (out_state_q == O_REL) && !im_ack;
        take       = (in_state_q == I_IDLE) && im_work &&
                     (!in_frame || byte_cnt_q != 2'd2 || !slot_busy_q || slot_free);
        use_byte   = take && in_frame;
        im_start_d = im_start;

        in_state_d = in_state_q;
        case (in_state_q)
            I_IDLE:  if (take) in_state_d = I_ACK;
            I_ACK:   in_state_d = I_REL;
            I_REL:   if (!im_work) in_state_d = I_IDLE;
            default: in_state_d = I_IDLE;
        endcase
        om_ack_d = (in_state_d != I_IDLE);

        pix_d      = pix_q;
        pix_vld_d  = 1'b0;
        byte_cnt_d = byte_cnt_q;
        frag_d     = frag_q;
        if (use_byte) begin
            case (byte_cnt_q)
                2'd0:    begin pix_d.b = im_data; byte_cnt_d = 2'd1; end
                2'd1:    begin pix_d.g = im_data; byte_cnt_d = 2'd2; end
                default: begin pix_d.r = im_data; byte_cnt_d = 2'd0; pix_vld_d = 1'b1; end
            endcase
        end
        // A byte landing on the falling edge counts before the leftover check.
        if (start_fall && byte_cnt_d != 2'd0) begin
            byte_cnt_d = 2'd0;
            frag_d     = 1'b1;
        end
        if (start_rise) begin
            byte_cnt_d = 2'd0;
            frag_d     = 1'b0;
        end

        slot_busy_d = slot_busy_q;
        if (slot_free) slot_busy_d = 1'b0;
        if (pix_vld_d) slot_busy_d = 1'b1;

        out_state_d = out_state_q;
        om_data_d   = om_data_q;
        om_bin_d    = om_bin_q;
        pix_cnt_d   = pix_cnt_q;
        case (out_state_q)
            O_IDLE: if (y_vld) begin
                out_state_d = O_REQ;
                om_data_d   = y;
                om_bin_d    = (y >= THRESH);
            end
            O_REQ: if (im_ack) begin
                out_state_d = O_REL;
                if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + CNT_ONE;
            end
            O_REL:   if (!im_ack) out_state_d = O_IDLE;
            default: out_state_d = O_IDLE;
        endcase
        om_work_d = (out_state_d == O_REQ);
        if (start_rise) pix_cnt_d = '0;

        start_d = start_q;
        drain_d = drain_q;
        if (start_rise) start_d = 1'b1;
        if (start_fall && start_q) drain_d = 1'b1;
        if (drain_q && !slot_busy_q && out_state_q == O_IDLE) begin
            start_d = 1'b0;
            drain_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q  <= I_IDLE;
            out_state_q <= O_IDLE;
            byte_cnt_q  <= '0;
            pix_q       <= '0;
            pix_vld_q   <= 1'b0;
            slot_busy_q <= 1'b0;
            start_q     <= 1'b0;
            drain_q     <= 1'b0;
            im_start_q  <= 1'b0;
            om_ack_q    <= 1'b0;
            om_work_q   <= 1'b0;
            om_data_q   <= '0;
            om_bin_q    <= 1'b0;
            pix_cnt_q   <= '0;
            frag_q      <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            byte_cnt_q  <= byte_cnt_d;
            pix_q       <= pix_d;
            pix_vld_q   <= pix_vld_d;
            slot_busy_q <= slot_busy_d;
            start_q     <= start_d;
            drain_q     <= drain_d;
            im_start_q  <= im_start_d;
            om_ack_q    <= om_ack_d;
            om_work_q   <= om_work_d;
            om_data_q   <= om_data_d;
            om_bin_q    <= om_bin_d;
            pix_cnt_q   <= pix_cnt_d;
            frag_q      <= frag_d;
        end
    end

    assign om_ack     = om_ack_q;
    assign om_start   = start_q;
    assign om_work    = om_work_q;
    assign om_data    = om_data_q;
    assign om_bin     = om_bin_q;
    assign om_pix_cnt = pix_cnt_q;
    assign om_frag    = frag_q;

endmodule

// File: tb/tb_rgb_to_gray.sv
// Directed bench for rgb_to_gray: luma model queue checked on every om_work cycle.
module tb_rgb_to_gray;

    localparam int CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             im_start = 1'b0;
    logic             im_work = 1'b0;
    logic [7:0]       im_data = 8'd0;
    logic             im_ack = 1'b0;
    logic             om_ack, om_start, om_work, om_bin, om_frag;
    logic [7:0]       om_data;
    logic [CNT_W-1:0] om_pix_cnt;

    typedef struct {
        int y;
        bit bin;
    } exp_t;

    exp_t exp_q[$];
    int   seen_y[$];
    int   frame_b[16];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, pulses = 0, work_cyc = 0, ack_cyc = 0, ack_delay = 2;
    bit   mon_prev = 1'b0;
    exp_t mon_cur;

    rgb_to_gray dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .im_start   (im_start),
        .im_work    (im_work),
        .im_data    (im_data),
        .om_ack     (om_ack),
        .om_start   (om_start),
        .om_work    (om_work),
        .om_data    (om_data),
        .om_bin     (om_bin),
        .im_ack     (im_ack),
        .om_pix_cnt (om_pix_cnt),
        .om_frag    (om_frag)
    );

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    task automatic push_exp(input int b, input int g, input int r);
        exp_t e;
        e.y   = (77 * r + 150 * g + 29 * b + 128) / 256;
        e.bin = (e.y >= 128);
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (om_ack == lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start_low(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!om_start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_byte(input int d, input string name);
        bit ok;
        im_data = 8'(d);
        im_work = 1'b1;
        wait_ack(1'b1, 40, ok);
        ack_cyc = cyc;
        chk({name, "_ack_hi"}, int'(ok), 1);
        im_work = 1'b0;
        wait_ack(1'b0, 40, ok);
        chk({name, "_ack_lo"}, int'(ok), 1);
    endtask

    task automatic run_frame(input int n, input string name);
        bit ok;
        for (int p = 0; p + 2 < n; p += 3) push_exp(frame_b[p], frame_b[p+1], frame_b[p+2]);
        im_start = 1'b1;
        repeat (2) @(negedge clk);
        chk({name, "_start"}, int'(om_start), 1);
        for (int i = 0; i < n; i++) send_byte(frame_b[i], name);
        im_start = 1'b0;
        wait_start_low(400, ok);
        chk({name, "_drain"}, int'(ok), 1);
        chk({name, "_q_empty"}, exp_q.size(), 0);
        chk({name, "_ack_low_at_end"}, int'(im_ack), 0);
    endtask

    // Compare process: every cycle om_work is high the held pixel must match the model.
    initial begin
        mon_cur.y = 0;
        mon_cur.bin = 1'b0;
        forever begin
            @(negedge clk);
            if (om_work && !mon_prev) begin
                pulses++;
                work_cyc = cyc;
                seen_y.push_back(int'(om_data));
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", exp_q.size(), 1);
                    mon_cur.y = -1;
                end else mon_cur = exp_q.pop_front();
            end
            if (om_work) begin
                chk("om_data", int'(om_data), mon_cur.y);
                chk("om_bin", int'(om_bin), int'(mon_cur.bin));
            end
            mon_prev = om_work;
        end
    end

    // Downstream: acknowledge each request after ack_delay cycles.
    initial forever begin
        @(negedge clk);
        if (om_work) begin
            repeat (ack_delay) @(negedge clk);
            if (om_work) begin
                im_ack = 1'b1;
                for (int i = 0; i < 20 && om_work; i++) @(negedge clk);
                if (om_work) chk("om_work_drop", int'(om_work), 0);
                im_ack = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int s0, p0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({om_ack, om_start, om_work, om_bin, om_frag, om_data, om_pix_cnt}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1 pixel, pure red
        s0 = seen_y.size(); p0 = pulses;
        frame_b[0] = 0; frame_b[1] = 0; frame_b[2] = 255;
        run_frame(3, "red");
        chk("red_latency", work_cyc - ack_cyc, 3);
        chk("red_pulses", pulses - p0, 1);
        chk("red_y", (seen_y.size() > s0) ? seen_y[s0] : -1, 77);
        chk("red_cnt", int'(om_pix_cnt), 1);
        chk("red_frag", int'(om_frag), 0);

        // white then black
        s0 = seen_y.size(); p0 = pulses;
        frame_b[0] = 255; frame_b[1] = 255; frame_b[2] = 255;
        frame_b[3] = 0;   frame_b[4] = 0;   frame_b[5] = 0;
        run_frame(6, "wb");
        chk("wb_pulses", pulses - p0, 2);
        chk("wb_y0", (seen_y.size() > s0) ? seen_y[s0] : -1, 255);
        chk("wb_y1", (seen_y.size() > s0 + 1) ? seen_y[s0+1] : -1, 0);
        chk("wb_cnt", int'(om_pix_cnt), 2);

        // downstream stall: second R byte must wait for the slot
        ack_delay = 50;
        s0 = seen_y.size(); p0 = pulses;
        push_exp(10, 200, 120);
        push_exp(255, 255, 255);
        im_start = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(10, "st_p0"); send_byte(200, "st_p0"); send_byte(120, "st_p0");
        send_byte(255, "st_b"); send_byte(255, "st_g");
        im_data = 8'd255;
        im_work = 1'b1;
        repeat (10) @(negedge clk);
        chk("stall_r_held", int'(om_ack), 0);
        chk("stall_work_wait", int'(om_work), 1);
        wait_ack(1'b1, 200, ok);
        chk("stall_r_ack", int'(ok), 1);
        im_work = 1'b0;
        wait_ack(1'b0, 40, ok);
        chk("stall_r_rel", int'(ok), 1);
        im_start = 1'b0;
        wait_start_low(400, ok);
        chk("stall_drain", int'(ok), 1);
        chk("stall_pulses", pulses - p0, 2);
        chk("stall_y0", (seen_y.size() > s0) ? seen_y[s0] : -1, 154);
        chk("stall_y1", (seen_y.size() > s0 + 1) ? seen_y[s0+1] : -1, 255);
        chk("stall_cnt", int'(om_pix_cnt), 2);
        chk("stall_q_empty", exp_q.size(), 0);
        ack_delay = 2;

        // 7 bytes: two pixels and a truncated third
        for (int i = 0; i < 7; i++) frame_b[i] = i + 1;
        run_frame(7, "frag");
        chk("frag_flag", int'(om_frag), 1);
        chk("frag_cnt", int'(om_pix_cnt), 2);

        // reset while a pixel is being offered
        ack_delay = 30;
        push_exp(255, 255, 255);
        im_start = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(255, "rst"); send_byte(255, "rst"); send_byte(255, "rst");
        for (int i = 0; i < 40 && !om_work; i++) @(negedge clk);
        chk("rst_pre_work", int'(om_work), 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outs", int'({om_ack, om_start, om_work, om_bin, om_frag, om_data, om_pix_cnt}), 0);
        im_start = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_idle_work", int'(om_work), 0);
        chk("rst_idle_cnt", int'(om_pix_cnt), 0);
        ack_delay = 2;

        // clean frame after reset
        s0 = seen_y.size();
        frame_b[0] = 0; frame_b[1] = 0; frame_b[2] = 255;
        run_frame(3, "post");
        chk("post_cnt", int'(om_pix_cnt), 1);
        chk("post_y", (seen_y.size() > s0) ? seen_y[s0] : -1, 77);
        chk("post_frag", int'(om_frag), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
